// File: rtl/vga_pkg.sv
// Shared scene constants, scene FSM state type and saturating brightness helpers.
// Fade states exist only when VGA_SCENE_FADE_EN is defined.
package vga_pkg;

    localparam logic [1:0] SCN_COLORBAR  = 2'd0;
    localparam logic [1:0] SCN_CHECKER   = 2'd1;
    localparam logic [1:0] SCN_MUST_LOGO = 2'd2;
    localparam logic [1:0] SCN_GRAY      = 2'd3;

    localparam logic [3:0] BRIGHT_MAX = 4'd15;

`ifdef VGA_SCENE_FADE_EN
    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } scene_state_e;
`else
    typedef enum logic [1:0] {
        SHOW = 2'd0
    } scene_state_e;
`endif

    function automatic logic [3:0] bright_dec(input logic [3:0] b);
        return (b == 4'd0) ? 4'd0 : b - 4'd1;
    endfunction

    function automatic logic [3:0] bright_inc(input logic [3:0] b);
        return (b == BRIGHT_MAX) ? BRIGHT_MAX : b + 4'd1;
    endfunction

endpackage

// File: rtl/vga_scene_ctrl_if.sv
// Control/status bundle between the VGA timing side, the key and the picture generator.
// The slave modport is the scene controller; master is whoever drives vsync/key/pause.
interface vga_scene_ctrl_if #(
    parameter int SCENE_W = 2
);
    logic               vsync;
    logic               key_n;
    logic               pause;
    logic [SCENE_W-1:0] scene_sel;
    logic [3:0]         bright;
    logic               scene_chg;
    logic               busy;
    logic [15:0]        frame_cnt;

    modport master (
        output vsync, key_n, pause,
        input  scene_sel, bright, scene_chg, busy, frame_cnt
    );

    modport slave (
        input  vsync, key_n, pause,
        output scene_sel, bright, scene_chg, busy, frame_cnt
    );
endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF sync + stable-for-DEBOUNCE_CYC filter, press pulse on 1->0.
// Latency 2 + DEBOUNCE_CYC cycles from pin to press_o; no backpressure (press_o is a 1-cycle pulse).
module key_debounce #(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic press_o
);
    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = sync2_q;
            press_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Idle level of an active-low key is 1, so reset there to avoid a phantom press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/vga_scene_ctrl.sv
// Scene sequencer: auto/key advance applied at frame ticks (2 cycles after vsync rise); optional fade (VGA_SCENE_FADE_EN).
// No backpressure: outputs are level/pulse status; a key press during a fade is dropped.
module vga_scene_ctrl
    import vga_pkg::*;
#(
    parameter int NUM_SCENES   = 4,
    parameter int DWELL_FRAMES = 180,
    parameter int DEBOUNCE_CYC = 250000
) (
    input logic             vga_clk,
    input logic             sys_rst,
    vga_scene_ctrl_if.slave bus
);
    localparam int SCENE_W = (NUM_SCENES > 1) ? $clog2(NUM_SCENES) : 1;
    localparam int DWELL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [SCENE_W-1:0] LAST_SCENE = SCENE_W'(NUM_SCENES - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);

    logic               vsync_q;
    logic               frame_tick_q;
    logic               press;
    logic               press_ok;
    logic               advance_req;
    logic               busy;
    logic [SCENE_W-1:0] scene_q, scene_d, scene_nxt;
    logic               scene_chg_q, scene_chg_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               pending_q, pending_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key_debounce (
        .clk    (vga_clk),
        .rst    (sys_rst),
        .key_n_i(bus.key_n),
        .press_o(press)
    );

`ifdef VGA_SCENE_FADE_EN
    scene_state_e state_q, state_d;
    logic [3:0]   bright_q, bright_d;

    assign busy = (state_q != SHOW);
`else
    assign busy = 1'b0;
`endif

    assign press_ok    = press & ~busy;
    assign advance_req = pending_q | press_ok | (~bus.pause & (dwell_q == DWELL_LAST));
    assign scene_nxt   = (scene_q == LAST_SCENE) ? '0 : scene_q + SCENE_W'(1);

    always_comb begin
        scene_d     = scene_q;
        scene_chg_d = 1'b0;
        dwell_d     = dwell_q;
        pending_d   = pending_q | press_ok;
        frame_cnt_d = frame_cnt_q + 16'(frame_tick_q);
`ifdef VGA_SCENE_FADE_EN
        state_d  = state_q;
        bright_d = bright_q;
`endif
        if (frame_tick_q) begin
`ifdef VGA_SCENE_FADE_EN
            unique case (state_q)
                SHOW: begin
                    if (advance_req) begin
                        pending_d = 1'b0;
                        dwell_d   = '0;
                        bright_d  = bright_dec(bright_q);
                        state_d   = FADE_OUT;
                    end else if (!bus.pause) begin
                        dwell_d = dwell_q + DWELL_W'(1);
                    end
                end
                FADE_OUT: begin
                    bright_d = bright_dec(bright_q);
                    // Swap the scene while the screen is black.
                    if (bright_q <= 4'd1) begin
                        scene_d     = scene_nxt;
                        scene_chg_d = 1'b1;
                        state_d     = FADE_IN;
                    end
                end
                FADE_IN: begin
                    bright_d = bright_inc(bright_q);
                    if (bright_q >= BRIGHT_MAX - 4'd1) begin
                        dwell_d = '0;
                        state_d = SHOW;
                    end
                end
                default: state_d = SHOW;
            endcase
`else
            if (advance_req) begin
                pending_d   = 1'b0;
                dwell_d     = '0;
                scene_d     = scene_nxt;
                scene_chg_d = 1'b1;
            end else if (!bus.pause) begin
                dwell_d = dwell_q + DWELL_W'(1);
            end
`endif
        end
    end

    // vsync_q resets high so a vsync already high at reset release is not seen as an edge.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            vsync_q      <= 1'b1;
            frame_tick_q <= 1'b0;
            scene_q      <= '0;
            scene_chg_q  <= 1'b0;
            dwell_q      <= '0;
            pending_q    <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            vsync_q      <= bus.vsync;
            frame_tick_q <= bus.vsync & ~vsync_q;
            scene_q      <= scene_d;
            scene_chg_q  <= scene_chg_d;
            dwell_q      <= dwell_d;
            pending_q    <= pending_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

`ifdef VGA_SCENE_FADE_EN
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state_q  <= SHOW;
            bright_q <= BRIGHT_MAX;
        end else begin
            state_q  <= state_d;
            bright_q <= bright_d;
        end
    end

    assign bus.bright = bright_q;
`else
    assign bus.bright = BRIGHT_MAX;
`endif

    assign bus.scene_sel = scene_q;
    assign bus.scene_chg = scene_chg_q;
    assign bus.busy      = busy;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_scene_ctrl.sv
// Directed bench for vga_scene_ctrl (NUM_SCENES=4, DWELL_FRAMES=3, DEBOUNCE_CYC=4).
// Expected scenes are queued by the stimulus; a monitor pops one per scene_chg pulse.
module tb_vga_scene_ctrl;

    logic clk = 1'b0;
    logic sys_rst;

    always #5 clk = ~clk;

    vga_scene_ctrl_if #(.SCENE_W(2)) bus ();

    vga_scene_ctrl #(
        .NUM_SCENES  (4),
        .DWELL_FRAMES(3),
        .DEBOUNCE_CYC(4)
    ) dut (
        .vga_clk(clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One synthetic frame: sync pulse low for 2 cycles, then high long enough for the tick to land.
    task automatic frame(input int n);
        repeat (n) begin
            bus.vsync = 1'b0;
            cyc(2);
            bus.vsync = 1'b1;
            cyc(4);
        end
    endtask

    task automatic press_key();
        bus.key_n = 1'b0;
        cyc(8);
        bus.key_n = 1'b1;
        cyc(12);
    endtask

    task automatic glitch_key();
        bus.key_n = 1'b0;
        cyc(2);
        bus.key_n = 1'b1;
        cyc(12);
    endtask

    // Debounced press pulse and frame tick land in the same cycle.
    task automatic press_with_tick();
        bus.vsync = 1'b0;
        cyc(2);
        bus.key_n = 1'b0;
        cyc(5);
        bus.vsync = 1'b1;
        cyc(3);
        bus.key_n = 1'b1;
        cyc(12);
    endtask

    always @(negedge clk) begin : monitor
        int e;
        if (!sys_rst && bus.scene_chg) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_scene_chg: scene_sel=%0d, no change was expected", bus.scene_sel);
            end else begin
                e = exp_q.pop_front();
                check("scene_chg_scene_sel", 32'(bus.scene_sel), 32'(e));
            end
        end
    end

    initial begin
        sys_rst   = 1'b1;
        bus.vsync = 1'b1;
        bus.key_n = 1'b1;
        bus.pause = 1'b0;
        cyc(3);
        sys_rst = 1'b0;
        @(negedge clk);
        check("reset_scene_sel", 32'(bus.scene_sel), 32'd0);
        check("reset_bright",    32'(bus.bright),    32'd15);
        check("reset_scene_chg", 32'(bus.scene_chg), 32'd0);
        check("reset_busy",      32'(bus.busy),      32'd0);
        check("reset_frame_cnt", 32'(bus.frame_cnt), 32'd0);

`ifdef VGA_SCENE_FADE_EN
        bus.pause = 1'b1;
        press_key();
        exp_q.push_back(1);
        frame(1);
        @(negedge clk);
        check("fade_start_bright", 32'(bus.bright), 32'd14);
        check("fade_start_busy",   32'(bus.busy),   32'd1);
        press_key();
        frame(14);
        @(negedge clk);
        check("fade_black_bright", 32'(bus.bright),    32'd0);
        check("fade_black_scene",  32'(bus.scene_sel), 32'd1);
        frame(15);
        @(negedge clk);
        check("fade_done_bright", 32'(bus.bright), 32'd15);
        check("fade_done_busy",   32'(bus.busy),   32'd0);
        frame(2);
        @(negedge clk);
        check("midfade_press_ignored_busy",  32'(bus.busy),      32'd0);
        check("midfade_press_ignored_scene", 32'(bus.scene_sel), 32'd1);
        press_key();
        exp_q.push_back(2);
        frame(22);
        @(negedge clk);
        check("fade_in_bright7", 32'(bus.bright),    32'd7);
        check("fade_in_scene",   32'(bus.scene_sel), 32'd2);
        check("fade_in_busy",    32'(bus.busy),      32'd1);
        check("fade_frame_cnt",  32'(bus.frame_cnt), 32'd54);
`else
        frame(2);
        @(negedge clk);
        check("auto_2_ticks_scene", 32'(bus.scene_sel), 32'd0);
        exp_q.push_back(1);
        frame(1);
        @(negedge clk);
        check("auto_3_ticks_scene", 32'(bus.scene_sel), 32'd1);
        check("auto_3_ticks_fcnt",  32'(bus.frame_cnt), 32'd3);
        for (int s = 2; s <= 4; s++) begin
            exp_q.push_back(s % 4);
            frame(3);
        end
        @(negedge clk);
        check("wrap_scene", 32'(bus.scene_sel), 32'd0);
        check("wrap_fcnt",  32'(bus.frame_cnt), 32'd12);

        bus.pause = 1'b1;
        frame(10);
        @(negedge clk);
        check("pause_scene", 32'(bus.scene_sel), 32'd0);
        check("pause_fcnt",  32'(bus.frame_cnt), 32'd22);
        press_key();
        exp_q.push_back(1);
        frame(1);
        @(negedge clk);
        check("paused_press_scene", 32'(bus.scene_sel), 32'd1);
        glitch_key();
        frame(2);
        @(negedge clk);
        check("glitch_scene", 32'(bus.scene_sel), 32'd1);

        bus.pause = 1'b0;
        frame(2);
        exp_q.push_back(2);
        press_with_tick();
        @(negedge clk);
        check("coincident_scene", 32'(bus.scene_sel), 32'd2);
        frame(2);
        @(negedge clk);
        check("coincident_single", 32'(bus.scene_sel), 32'd2);
        exp_q.push_back(3);
        frame(1);
        @(negedge clk);
        check("post_coincident_scene", 32'(bus.scene_sel), 32'd3);
        check("post_coincident_fcnt",  32'(bus.frame_cnt), 32'd31);
`endif

        sys_rst = 1'b1;
        cyc(1);
        sys_rst = 1'b0;
        @(negedge clk);
        check("rerst_scene_sel", 32'(bus.scene_sel), 32'd0);
        check("rerst_bright",    32'(bus.bright),    32'd15);
        check("rerst_busy",      32'(bus.busy),      32'd0);
        check("rerst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        cyc(4);
        check("scene_chg_all_seen", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
